ser_tx: RTL and testbench
=========================

// Module: ser_tx
// PURPOSE
//  Parametrised parallel-to-serial transmitter; next generation of the 4-bit round-robin decoder.
//  Captures a WIDTH-bit word per lane via valid/ready handshake, shifts it out one bit per bit
//  period, LSB- or MSB-first, with programmable bit rate and a frame strobe marking bit 0.
//  Sits between the slave's parallel data path and the serial line driver(s).
// PARAMETERS
//  WIDTH      4     bits per word (>=2)
//  LANES      1     independent serial outputs sharing one handshake and timing
//  DIV        1     clk cycles per bit (>=1); DIV=1 gives one bit per clk
//  MSB_FIRST  0     0: bit 0 sent first; 1: bit WIDTH-1 sent first
//  IDLE_LVL   1'b0  line level driven when no word is in flight
// PORTS
//  clk    in   1            system clock, rising edge
//  rst    in   1            asynchronous reset, active-high
//  din    in   LANES*WIDTH  parallel words; lane k = din[k*WIDTH +: WIDTH]
//  load   in   1            din valid
//  ready  out  1            block accepts din this cycle (combinational from state/counters)
//  out    out  LANES        serial data, registered
//  frame  out  1            high for the whole bit period of the first bit of each word, registered
//  busy   out  1            word in flight, registered
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE, out={LANES{IDLE_LVL}}, frame=0, busy=0, bit/div counters=0,
//   shift regs=0. Deassertion synchronous to clk; first accept possible on the first edge after.
//  States: IDLE, SHIFT.
//  Accept: edge with load&&ready. Captures din, and on that same edge out<=first bit of each lane,
//   frame<=1, busy<=1, bit_cnt<=0, div_cnt<=0, state<=SHIFT. load with ready=0 is ignored (no queue).
//  ready = (state==IDLE) | (state==SHIFT & bit_cnt==WIDTH-1 & div_cnt==DIV-1).
//  SHIFT: div_cnt counts 0..DIV-1; at DIV-1 it wraps to 0 and the next bit is driven (bit_cnt+1).
//   Each bit held exactly DIV clk cycles. frame=1 only while bit_cnt==0.
//  End of word (bit_cnt==WIDTH-1, div_cnt==DIV-1): if load, accept new word (back-to-back, no gap,
//   frame re-asserts); else state<=IDLE, out<=IDLE_LVL, frame<=0, busy<=0.
//  Latency: first bit on out one clk after the accepting edge is sampled; word occupies WIDTH*DIV
//   cycles; sustained throughput 1 word per WIDTH*DIV cycles.
//  Bit order: MSB_FIRST=0 -> shift right, out=sr[0]; MSB_FIRST=1 -> shift left, out=sr[WIDTH-1].
//  Counters sized $clog2(WIDTH) and $clog2(DIV) (min 1 bit); DIV=1 -> div_cnt constant 0, no stall.
//  No undefined state: any illegal encoding returns to IDLE with outputs at reset values.
//  din changes after acceptance have no effect on the word in flight.
//  rst mid-word: word is aborted immediately, outputs take reset values asynchronously.
// STRUCTURE
//  Shared header ser_defs.vh: state encodings (ST_IDLE, ST_SHIFT), CLOG2-safe width macro,
//   shared with the future ser_rx receiver.
//  One sub-module: ser_bit_tick (DIV counter, emits tick on div_cnt==DIV-1, clear on accept).
//  Per-lane shift registers built with a generate loop; handshake/FSM shared across lanes.
// TESTING
//  1 Reset: rst=1 mid-stream -> out=IDLE_LVL, frame=0, busy=0, ready=1 without waiting for clk.
//  2 WIDTH=4,DIV=1,LSB: load din=4'b1011 one cycle -> out 1,1,0,1 on 4 consecutive cycles,
//    frame high on first only, then out=IDLE_LVL, busy=0.
//  3 Back-to-back: load held with 4'hA then 4'h5, MSB_FIRST=1 -> out 1,0,1,0,0,1,0,1 with no gap,
//    frame high on cycles 0 and 4, ready high on cycles 3 and 7.
//  4 DIV=3,WIDTH=8: din=8'h81 -> each bit held 3 cycles, 24-cycle word, ready only on cycle 23.
//  5 LANES=2: din={4'hF,4'h0} -> lane1 all ones, lane0 all zeros, identical frame timing.
//  6 load pulsed while busy (not last cycle) with din=4'h3 -> ignored; word in flight unchanged.

Source files
------------

// File: rtl/ser_tx_pkg.sv
// Shared definitions for the serial transmitter: FSM encoding and counter sizing.
package ser_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    // Counter width for values 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ser_tx_bit_tick.sv
// Bit-period divider: counts 0..DIV-1 while enabled, tick marks the last cycle of a bit.
module ser_bit_tick
    import ser_tx_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int DW = clog2_min1(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;

    // With DIV=1 LAST is 0, so the counter never leaves 0 and tick stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (!en || clr || div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign tick = (div_cnt == LAST);

endmodule

// File: rtl/ser_tx.sv
// Parallel-to-serial transmitter: one valid/ready handshake shared by LANES shift registers.
module ser_tx
    import ser_tx_pkg::*;
#(
    parameter int   WIDTH     = 4,
    parameter int   LANES     = 1,
    parameter int   DIV       = 1,
    parameter int   MSB_FIRST = 0,
    parameter logic IDLE_LVL  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES*WIDTH-1:0] din,
    input  logic                   load,
    output logic                   ready,
    output logic [LANES-1:0]       out,
    output logic                   frame,
    output logic                   busy
);

    localparam int BW = clog2_min1(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    // Handshake: a word is taken on any rising edge where load && ready.
    // ready is combinational so a new word can follow the last bit with no gap.
    ser_state_t             state, state_nxt;
    logic [BW-1:0]          bit_cnt;
    logic [LANES*WIDTH-1:0] sr, sr_shift;
    logic [LANES-1:0]       first_bit, next_bit;
    logic                   tick, last, accept, adv;

    ser_bit_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_SHIFT),
        .clr  (accept),
        .tick (tick)
    );

    assign last   = (state == ST_SHIFT) && (bit_cnt == BIT_LAST) && tick;
    assign ready  = (state == ST_IDLE) || last;
    assign accept = load && ready;
    assign adv    = (state == ST_SHIFT) && tick && (bit_cnt != BIT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last)   state_nxt = accept ? ST_SHIFT : ST_IDLE;
            default:              state_nxt = ST_IDLE;
        endcase
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [WIDTH-1:0] word, cur;
        assign word = din[k*WIDTH +: WIDTH];
        assign cur  = sr[k*WIDTH +: WIDTH];
        if (MSB_FIRST != 0) begin : g_msb
            assign sr_shift[k*WIDTH +: WIDTH] = {cur[WIDTH-2:0], 1'b0};
            assign first_bit[k] = word[WIDTH-1];
            assign next_bit[k]  = cur[WIDTH-2];
        end else begin : g_lsb
            assign sr_shift[k*WIDTH +: WIDTH] = {1'b0, cur[WIDTH-1:1]};
            assign first_bit[k] = word[0];
            assign next_bit[k]  = cur[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Leaving SHIFT (or any unexpected encoding) drives every output back to its idle value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            sr      <= '0;
            out     <= {LANES{IDLE_LVL}};
            frame   <= 1'b0;
            busy    <= 1'b0;
        end else if (accept) begin
            bit_cnt <= '0;
            sr      <= din;
            out     <= first_bit;
            frame   <= 1'b1;
            busy    <= 1'b1;
        end else if (state_nxt != ST_SHIFT) begin
            bit_cnt <= '0;
            sr      <= '0;
            out     <= {LANES{IDLE_LVL}};
            frame   <= 1'b0;
            busy    <= 1'b0;
        end else if (adv) begin
            bit_cnt <= bit_cnt + BW'(1);
            sr      <= sr_shift;
            out     <= next_bit;
            frame   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ser_tx.sv
// Directed bench for ser_tx over three configurations, checked against an expected-value queue.
module tb_ser_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // a: WIDTH=4 LANES=2 DIV=1 LSB-first, idle 0
    logic [7:0] din_a = '0;
    logic       load_a = 1'b0;
    logic       ready_a, frame_a, busy_a;
    logic [1:0] out_a;
    // b: WIDTH=4 LANES=1 DIV=1 MSB-first, idle 1
    logic [3:0] din_b = '0;
    logic       load_b = 1'b0;
    logic       ready_b, frame_b, busy_b;
    logic [0:0] out_b;
    // c: WIDTH=8 LANES=1 DIV=3 LSB-first, idle 0
    logic [7:0] din_c = '0;
    logic       load_c = 1'b0;
    logic       ready_c, frame_c, busy_c;
    logic [0:0] out_c;

    ser_tx #(.WIDTH(4), .LANES(2), .DIV(1), .MSB_FIRST(0), .IDLE_LVL(1'b0)) u_a (
        .clk(clk), .rst(rst), .din(din_a), .load(load_a),
        .ready(ready_a), .out(out_a), .frame(frame_a), .busy(busy_a));

    ser_tx #(.WIDTH(4), .LANES(1), .DIV(1), .MSB_FIRST(1), .IDLE_LVL(1'b1)) u_b (
        .clk(clk), .rst(rst), .din(din_b), .load(load_b),
        .ready(ready_b), .out(out_b), .frame(frame_b), .busy(busy_b));

    ser_tx #(.WIDTH(8), .LANES(1), .DIV(3), .MSB_FIRST(0), .IDLE_LVL(1'b0)) u_c (
        .clk(clk), .rst(rst), .din(din_c), .load(load_c),
        .ready(ready_c), .out(out_c), .frame(frame_c), .busy(busy_c));

    // Entry layout: [15:8] lane outputs, [2] ready, [1] busy, [0] frame.
    logic [15:0] exp_a_q[$];
    logic [15:0] exp_b_q[$];
    logic [15:0] exp_c_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic push_entry(input int which, input logic [15:0] e);
        case (which)
            0:       exp_a_q.push_back(e);
            1:       exp_b_q.push_back(e);
            default: exp_c_q.push_back(e);
        endcase
    endtask

    // One entry per clk of the word, derived from the bit-serial definition.
    task automatic push_word(input int which, input int w, input int div, input bit msb,
                             input int lanes, input logic [31:0] d);
        for (int c = 0; c < w * div; c++) begin
            int b;
            int bi;
            logic [15:0] e;
            b  = c / div;
            bi = msb ? (w - 1 - b) : b;
            e  = '0;
            for (int k = 0; k < lanes; k++) e[8 + k] = d[k * w + bi];
            e[2] = (c == w * div - 1);
            e[1] = 1'b1;
            e[0] = (b == 0);
            push_entry(which, e);
        end
    endtask

    task automatic push_idle(input int which, input int lanes, input logic lvl);
        logic [15:0] e;
        e = '0;
        for (int k = 0; k < lanes; k++) e[8 + k] = lvl;
        e[2] = 1'b1;
        push_entry(which, e);
    endtask

    task automatic check(input int which, input string tag);
        logic [15:0] obs;
        logic [15:0] exp_v;
        bit          have;
        obs   = '0;
        exp_v = '0;
        have  = 1'b0;
        case (which)
            0: begin
                obs[9:8] = out_a; obs[2] = ready_a; obs[1] = busy_a; obs[0] = frame_a;
                if (exp_a_q.size() > 0) begin exp_v = exp_a_q.pop_front(); have = 1'b1; end
            end
            1: begin
                obs[8] = out_b[0]; obs[2] = ready_b; obs[1] = busy_b; obs[0] = frame_b;
                if (exp_b_q.size() > 0) begin exp_v = exp_b_q.pop_front(); have = 1'b1; end
            end
            default: begin
                obs[8] = out_c[0]; obs[2] = ready_c; obs[1] = busy_c; obs[0] = frame_c;
                if (exp_c_q.size() > 0) begin exp_v = exp_c_q.pop_front(); have = 1'b1; end
            end
        endcase
        n_assert++;
        if (!have) begin
            n_fail++;
            $error("FAIL %s: observed %h expected <no scoreboard entry>", tag, obs);
        end else begin
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            end
        end
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        @(negedge clk);
        push_idle(0, 2, 1'b0); check(0, "reset_a");
        push_idle(1, 1, 1'b1); check(1, "reset_b");
        push_idle(2, 1, 1'b0); check(2, "reset_c");
        rst = 1'b0;
        @(negedge clk);
        push_idle(0, 2, 1'b0); check(0, "post_reset_a");

        // Single word, LSB first: lane0 1011 -> 1,1,0,1
        din_a = {4'h6, 4'b1011};
        load_a = 1'b1;
        push_word(0, 4, 1, 1'b0, 2, {24'h0, din_a});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check(0, "single_word_bit");
            if (i == 0) load_a = 1'b0;
        end
        push_idle(0, 2, 1'b0);
        @(negedge clk);
        check(0, "single_word_idle");

        // Back-to-back MSB first, load held: A then 5, din changed after first accept
        din_b = 4'hA;
        load_b = 1'b1;
        push_word(1, 4, 1, 1'b1, 1, 32'hA);
        push_word(1, 4, 1, 1'b1, 1, 32'h5);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check(1, "b2b_bit");
            if (i == 0) din_b = 4'h5;
            if (i == 4) load_b = 1'b0;
        end
        push_idle(1, 1, 1'b1);
        @(negedge clk);
        check(1, "b2b_idle");

        // DIV=3, WIDTH=8: 24-cycle word, din scrubbed right after accept
        din_c = 8'h81;
        load_c = 1'b1;
        push_word(2, 8, 3, 1'b0, 1, 32'h81);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            check(2, "div3_bit");
            if (i == 0) begin load_c = 1'b0; din_c = 8'h00; end
        end
        push_idle(2, 1, 1'b0);
        @(negedge clk);
        check(2, "div3_idle");

        // Two lanes: lane1 all ones, lane0 all zeros
        din_a = {4'hF, 4'h0};
        load_a = 1'b1;
        push_word(0, 4, 1, 1'b0, 2, {24'h0, din_a});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check(0, "two_lane_bit");
            if (i == 0) load_a = 1'b0;
        end
        push_idle(0, 2, 1'b0);
        @(negedge clk);
        check(0, "two_lane_idle");

        // load pulsed while busy (not last bit) is ignored
        din_a = {4'h5, 4'hC};
        load_a = 1'b1;
        push_word(0, 4, 1, 1'b0, 2, {24'h0, din_a});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check(0, "ignore_load_bit");
            if (i == 0) load_a = 1'b0;
            if (i == 1) begin din_a = 8'h33; load_a = 1'b1; end
            if (i == 2) load_a = 1'b0;
        end
        push_idle(0, 2, 1'b0);
        @(negedge clk);
        check(0, "ignore_load_idle");

        // Reset mid-word: outputs return to idle before any clock edge
        din_a = 8'h9E;
        load_a = 1'b1;
        push_word(0, 4, 1, 1'b0, 2, {24'h0, din_a});
        @(negedge clk);
        check(0, "pre_abort_bit0");
        load_a = 1'b0;
        @(negedge clk);
        check(0, "pre_abort_bit1");
        rst = 1'b1;
        #1;
        exp_a_q.delete();
        push_idle(0, 2, 1'b0); check(0, "async_reset_a");
        push_idle(1, 1, 1'b1); check(1, "async_reset_b");
        push_idle(2, 1, 1'b0); check(2, "async_reset_c");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_idle(0, 2, 1'b0); check(0, "after_abort_idle");

        // Recovery word after reset
        din_a = 8'h21;
        load_a = 1'b1;
        push_word(0, 4, 1, 1'b0, 2, {24'h0, din_a});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check(0, "recover_bit");
            if (i == 0) load_a = 1'b0;
        end
        push_idle(0, 2, 1'b0);
        @(negedge clk);
        check(0, "recover_idle");

        n_assert++;
        assert (exp_a_q.size() + exp_b_q.size() + exp_c_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0",
                   exp_a_q.size() + exp_b_q.size() + exp_c_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
